// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: the memory read port toward instruction memory, the
// decode-side valid/ready instruction stream and the branch redirect inputs.
interface instruction_fetch_if #(
    parameter int unsigned WIDTH = 22
);
    logic             en_i;
    logic [WIDTH-1:0] imem_a_o;
    logic [WIDTH-1:0] imem_rd_i;
    logic [WIDTH-1:0] instr_o;
    logic [WIDTH-1:0] instr_pc_o;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic             redirect_i;
    logic [WIDTH-1:0] redirect_pc_i;
    logic             redirect_misalign_o;

    // Fetch unit side
    modport master (
        input  en_i, imem_rd_i, instr_ready_i, redirect_i, redirect_pc_i,
        output imem_a_o, instr_o, instr_pc_o, instr_valid_o, redirect_misalign_o
    );

    // Memory / decode / execute side
    modport slave (
        output en_i, imem_rd_i, instr_ready_i, redirect_i, redirect_pc_i,
        input  imem_a_o, instr_o, instr_pc_o, instr_valid_o, redirect_misalign_o
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads one word per cycle from instruction
// memory into a small FIFO and hands words to decode over valid/ready.
// A branch redirect flushes the FIFO and reloads the PC (word aligned).
module instruction_fetch #(
    parameter int unsigned      WIDTH      = 22,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] fifo_instr_r [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             misalign_r;

    logic             valid_s;
    logic             pop_s;
    logic             push_s;

    // Next sequential fetch address; wraps naturally at 2^WIDTH.
    function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] pc);
        return pc + WIDTH'(4);
    endfunction

    // Force a branch target onto a word boundary.
    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:2], 2'b00};
    endfunction

    assign valid_s                 = (count_r != '0);
    assign bus.imem_a_o            = pc_r;
    assign bus.instr_valid_o       = valid_s;
    assign bus.instr_o             = valid_s ? fifo_instr_r[head_r] : '0;
    assign bus.instr_pc_o          = valid_s ? fifo_pc_r[head_r] : '0;
    assign bus.redirect_misalign_o = misalign_r;

    // Handshake decode: a redirect suppresses both push and pop; a full FIFO
    // still accepts a word when the head leaves in the same cycle.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (bus.redirect_i) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = valid_s & bus.instr_ready_i;
            push_s = (state_r == FETCH) & bus.en_i &
                     ((count_r < CNT_W'(FIFO_DEPTH)) | pop_s);
        end
    end

    // FIFO storage: capture {memory word, its address} at the tail on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_instr_r[i] <= '0;
                fifo_pc_r[i]    <= '0;
            end
        end else if (push_s) begin
            fifo_instr_r[tail_r] <= bus.imem_rd_i;
            fifo_pc_r[tail_r]    <= pc_r;
        end
    end

    // Control state: FSM, PC, FIFO pointers/count and misalign pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            misalign_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    state_r <= bus.en_i ? FETCH : IDLE;
                FETCH:   state_r <= bus.en_i ? FETCH : IDLE;
                default: state_r <= IDLE;
            endcase

            misalign_r <= bus.redirect_i ? (|bus.redirect_pc_i[1:0]) : 1'b0;

            if (bus.redirect_i) begin
                pc_r    <= word_align(bus.redirect_pc_i);
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
            end else begin
                if (push_s) begin
                    pc_r   <= next_pc(pc_r);
                    tail_r <= tail_r + PTR_W'(1);
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a scoreboard queue holds the expected fetch
// addresses of each scenario; every accepted word is popped and compared
// against the address and the memory model's data.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [21:0] exp_q [$];
    logic [21:0] exp_pc;
    logic [21:0] exp_a;

    instruction_fetch_if #(.WIDTH(22)) bus ();

    instruction_fetch #(.WIDTH(22), .RESET_PC(22'h0), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: combinational read, nonzero at address 0.
    function automatic logic [21:0] mem_word(input logic [21:0] a);
        return (a * 22'd7) ^ 22'h2A5A5;
    endfunction

    assign bus.imem_rd_i = mem_word(bus.imem_a_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.en_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 22'h0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (bus.instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.instr_valid_o); else pass_cnt++;
        total_cnt++; if (bus.instr_o !== 22'h0) $display("FAIL reset_instr: got %h, required 000000", bus.instr_o); else pass_cnt++;
        total_cnt++; if (bus.instr_pc_o !== 22'h0) $display("FAIL reset_pc: got %h, required 000000", bus.instr_pc_o); else pass_cnt++;
        total_cnt++; if (bus.imem_a_o !== 22'h0) $display("FAIL reset_imem_a: got %h, required 000000", bus.imem_a_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b, required 0", bus.redirect_misalign_o); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(22'(4 * i));
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_a = (k < 2) ? 22'h0 : 22'(4 * (k - 1));
            total_cnt++; if (bus.imem_a_o !== exp_a) $display("FAIL stream_imem_a c%0d: got %h, required %h", k, bus.imem_a_o, exp_a); else pass_cnt++;
            total_cnt++; if (bus.instr_valid_o !== (k >= 2)) $display("FAIL stream_valid c%0d: got %b, required %b", k, bus.instr_valid_o, (k >= 2)); else pass_cnt++;
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL stream_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL stream_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL stream_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp_a = (k < 2) ? 22'h0 : ((k == 2) ? 22'h4 : 22'h8);
            total_cnt++; if (bus.imem_a_o !== exp_a) $display("FAIL bp_imem_a c%0d: got %h, required %h", k, bus.imem_a_o, exp_a); else pass_cnt++;
            if (k >= 2) begin
                total_cnt++; if (bus.instr_pc_o !== 22'h0) $display("FAIL bp_head c%0d: got %h, required 000000", k, bus.instr_pc_o); else pass_cnt++;
            end
            tick();
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(22'(4 * i));
        bus.instr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total_cnt++; if (bus.instr_valid_o !== 1'b1) $display("FAIL bp_gap c%0d: got %b, required 1", k, bus.instr_valid_o); else pass_cnt++;
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL bp_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_redirect_full();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b0;
        repeat (4) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 22'h3C;
        bus.instr_ready_i = 1'b1;
        tick();
        bus.redirect_i = 1'b0;
        total_cnt++; if (bus.instr_valid_o !== 1'b0) $display("FAIL redir_valid: got %b, required 0", bus.instr_valid_o); else pass_cnt++;
        total_cnt++; if (bus.imem_a_o !== 22'h3C) $display("FAIL redir_imem_a: got %h, required 00003c", bus.imem_a_o); else pass_cnt++;
        total_cnt++; if (bus.redirect_misalign_o !== 1'b0) $display("FAIL redir_aligned_flag: got %b, required 0", bus.redirect_misalign_o); else pass_cnt++;
        exp_q.delete();
        exp_q.push_back(22'h3C);
        exp_q.push_back(22'h40);
        exp_q.push_back(22'h44);
        for (int k = 0; k < 4; k++) begin
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL redir_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL redir_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL redir_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        repeat (3) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 22'h3E;
        tick();
        bus.redirect_i = 1'b0;
        total_cnt++; if (bus.redirect_misalign_o !== 1'b1) $display("FAIL misalign_pulse: got %b, required 1", bus.redirect_misalign_o); else pass_cnt++;
        total_cnt++; if (bus.imem_a_o !== 22'h3C) $display("FAIL misalign_imem_a: got %h, required 00003c", bus.imem_a_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.redirect_misalign_o !== 1'b0) $display("FAIL misalign_width: got %b, required 0", bus.redirect_misalign_o); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        repeat (3) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 22'h3FFFFC;
        tick();
        bus.redirect_i = 1'b0;
        exp_q.delete();
        exp_q.push_back(22'h3FFFFC);
        exp_q.push_back(22'h0);
        exp_q.push_back(22'h4);
        for (int k = 0; k < 4; k++) begin
            if (k < 2) begin
                exp_a = (k == 0) ? 22'h3FFFFC : 22'h0;
                total_cnt++; if (bus.imem_a_o !== exp_a) $display("FAIL wrap_imem_a c%0d: got %h, required %h", k, bus.imem_a_o, exp_a); else pass_cnt++;
            end
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL wrap_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL wrap_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        repeat (3) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 22'h100;
        tick();
        bus.redirect_pc_i = 22'h200;
        tick();
        bus.redirect_i = 1'b0;
        total_cnt++; if (bus.instr_valid_o !== 1'b0) $display("FAIL b2b_valid: got %b, required 0", bus.instr_valid_o); else pass_cnt++;
        total_cnt++; if (bus.imem_a_o !== 22'h200) $display("FAIL b2b_imem_a: got %h, required 000200", bus.imem_a_o); else pass_cnt++;
        exp_q.delete();
        exp_q.push_back(22'h200);
        exp_q.push_back(22'h204);
        for (int k = 0; k < 3; k++) begin
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL b2b_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL b2b_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_idle_hold();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b0;
        repeat (5) tick();
        bus.en_i = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            total_cnt++;
            if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 22'h0 || bus.imem_a_o !== 22'h8)
                $display("FAIL idle_hold c%0d: got valid %b pc %h a %h, required 1 000000 000008", k, bus.instr_valid_o, bus.instr_pc_o, bus.imem_a_o);
            else pass_cnt++;
            tick();
        end
        exp_q.push_back(22'h0);
        exp_q.push_back(22'h4);
        bus.instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL idle_sb: got pc %h, required no word", bus.instr_pc_o);
                else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_word(exp_pc))
                        $display("FAIL idle_sb: got pc %h instr %h, required pc %h instr %h", bus.instr_pc_o, bus.instr_o, exp_pc, mem_word(exp_pc));
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++; if (bus.instr_valid_o !== 1'b0) $display("FAIL idle_empty: got %b, required 0", bus.instr_valid_o); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL idle_drain: got %0d left, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.en_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        repeat (4) tick();
        total_cnt++; if (bus.instr_valid_o !== 1'b1) $display("FAIL areset_pre_valid: got %b, required 1", bus.instr_valid_o); else pass_cnt++;
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_o !== 22'h0 || bus.instr_pc_o !== 22'h0 || bus.imem_a_o !== 22'h0)
            $display("FAIL areset_immediate: got valid %b instr %h pc %h a %h, required 0 000000 000000 000000", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.imem_a_o);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        bus.en_i = 1'b0;
        bus.instr_ready_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.en_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 22'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_idle_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
